// File: rtl/branch_redirect_ctrl.sv
// Execute-stage control-flow resolver: decodes JAL/JALR/branches in EX and drives squash, pc_source and pipeline flushes.
// Latency: 1 cycle from EX evaluation to squash/pc_source. All outputs come straight from flops.
// Backpressure: stall freezes the FSM in REDIRECT and pauses the FLUSH countdown. Optional stats: BRANCH_REDIRECT_STATS_EN.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2  // bubble cycles after a redirect, 1..3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ex_valid,
  input  logic [6:0] ex_opcode,
  input  logic [2:0] ex_func3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  input  logic       stall,
  output logic       squash,
  output logic [2:0] pc_source,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       busy
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [15:0] redirect_count,
  output logic [15:0] taken_branch_count
`endif
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] SEL_PC4    = 3'd0;
  localparam logic [2:0] SEL_JALR   = 3'd1;
  localparam logic [2:0] SEL_BRANCH = 3'd2;
  localparam logic [2:0] SEL_JAL    = 3'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t     state, state_d;
  logic [1:0] cnt, cnt_d;
  logic       redirect;
  logic       taken;
  logic [2:0] sel;
  logic       capture;
  logic       squash_d;
  logic [2:0] pc_source_d;
  logic       flush_d;

  // Decode the EX instruction into a redirect request and its PC mux select.
  always_comb begin
    redirect = 1'b0;
    sel      = SEL_PC4;
    taken    = 1'b0;
    case (ex_func3)
      3'b000:  taken = br_eq;
      3'b001:  taken = ~br_eq;
      3'b100:  taken = br_lt;
      3'b101:  taken = ~br_lt;
      3'b110:  taken = br_ltu;
      3'b111:  taken = ~br_ltu;
      default: taken = 1'b0;  // 010/011 are not branch encodings
    endcase
    case (ex_opcode)
      OP_JAL: begin
        redirect = 1'b1;
        sel      = SEL_JAL;
      end
      OP_JALR: begin
        redirect = 1'b1;
        sel      = SEL_JALR;
      end
      OP_BRANCH: begin
        redirect = taken;
        sel      = taken ? SEL_BRANCH : SEL_PC4;
      end
      default: begin
        redirect = 1'b0;
        sel      = SEL_PC4;
      end
    endcase
  end

  // Next-state, bubble counter and next-output computation.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    case (state)
      IDLE: begin
        // A stalled EX instruction is frozen and simply re-evaluated next cycle.
        if (ex_valid && !stall && redirect) begin
          state_d = REDIRECT;
          capture = 1'b1;
        end
      end
      REDIRECT: begin
        if (!stall) begin
          state_d = FLUSH;
          cnt_d   = 2'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        // EX holds wrong-path bubbles here, so ex_valid/redirect are ignored.
        if (!stall) begin
          if (cnt <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt - 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    squash_d = (state_d == REDIRECT);
    // The pc_source flop doubles as the latched select while REDIRECT is held.
    if (!squash_d)
      pc_source_d = SEL_PC4;
    else if (capture)
      pc_source_d = sel;
    else
      pc_source_d = pc_source;
    flush_d = (state_d != IDLE);
  end

  // State, counter and registered outputs; reset aborts any redirect at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      squash     <= 1'b0;
      pc_source  <= SEL_PC4;
      flush_ifid <= 1'b0;
      flush_idex <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      squash     <= squash_d;
      pc_source  <= pc_source_d;
      flush_ifid <= flush_d;
      flush_idex <= flush_d;
      busy       <= flush_d;
    end
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  // Redirect and taken-branch counters, bumped on each capture and wrapping at 16 bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      redirect_count     <= 16'd0;
      taken_branch_count <= 16'd0;
    end else if (capture) begin
      redirect_count <= redirect_count + 16'd1;
      if (sel == SEL_BRANCH)
        taken_branch_count <= taken_branch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed, table-driven bench for branch_redirect_ctrl with FLUSH_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge; inputs change right after sampling.
// Hand sequences cover stall in REDIRECT/FLUSH, back-to-back redirects and async reset mid-flush.
module tb_branch_redirect_ctrl;

  logic       CLK;
  logic       RST;
  logic       ex_valid;
  logic [6:0] ex_opcode;
  logic [2:0] ex_func3;
  logic       br_eq;
  logic       br_lt;
  logic       br_ltu;
  logic       stall;
  logic       squash;
  logic [2:0] pc_source;
  logic       flush_ifid;
  logic       flush_idex;
  logic       busy;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [15:0] redirect_count;
  logic [15:0] taken_branch_count;
`endif

  branch_redirect_ctrl #(.FLUSH_CYCLES(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ex_valid   (ex_valid),
    .ex_opcode  (ex_opcode),
    .ex_func3   (ex_func3),
    .br_eq      (br_eq),
    .br_lt      (br_lt),
    .br_ltu     (br_ltu),
    .stall      (stall),
    .squash     (squash),
    .pc_source  (pc_source),
    .flush_ifid (flush_ifid),
    .flush_idex (flush_idex),
    .busy       (busy)
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    .redirect_count     (redirect_count),
    .taken_branch_count (taken_branch_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] RTYP = 7'b0110011;

  // Expected output bundles: {squash, pc_source[2:0], flush_ifid, flush_idex, busy}
  localparam logic [6:0] O_IDLE  = 7'b0_000_000;
  localparam logic [6:0] O_FLUSH = 7'b0_000_111;

  typedef struct {
    logic       valid;
    logic [6:0] op;
    logic [2:0] f3;
    logic       eq;
    logic       lt;
    logic       ltu;
    logic       taken;
    logic [2:0] sel;
  } vec_t;

  vec_t vecs[17];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] o_redir(input logic [2:0] s);
    return {1'b1, s, 3'b111};
  endfunction

  task automatic chk(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {squash, pc_source, flush_ifid, flush_idex, busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (squash,pc_source,flush_ifid,flush_idex,busy)",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic eq, input logic lt, input logic ltu);
    ex_valid  = v;
    ex_opcode = op;
    ex_func3  = f3;
    br_eq     = eq;
    br_lt     = lt;
    br_ltu    = ltu;
  endtask

  initial begin
    //          valid op    f3      eq    lt    ltu   taken sel
    vecs[0]  = '{1'b1, JAL,  3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
    vecs[1]  = '{1'b1, JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    vecs[2]  = '{1'b1, BR,   3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2}; // BEQ eq
    vecs[3]  = '{1'b1, BR,   3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0}; // BEQ ne
    vecs[4]  = '{1'b1, BR,   3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}; // BNE eq
    vecs[5]  = '{1'b1, BR,   3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2}; // BNE ne
    vecs[6]  = '{1'b1, BR,   3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2}; // BLT lt
    vecs[7]  = '{1'b1, BR,   3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}; // BLT, only ltu
    vecs[8]  = '{1'b1, BR,   3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}; // BGE lt
    vecs[9]  = '{1'b1, BR,   3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2}; // BLTU ltu
    vecs[10] = '{1'b1, BR,   3'b110, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}; // BLTU, only lt
    vecs[11] = '{1'b1, BR,   3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2}; // BGEU !ltu
    vecs[12] = '{1'b1, BR,   3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0}; // BGEU ltu
    vecs[13] = '{1'b1, BR,   3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0}; // func3 010
    vecs[14] = '{1'b1, BR,   3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; // func3 011
    vecs[15] = '{1'b0, JAL,  3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}; // bubble
    vecs[16] = '{1'b1, RTYP, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0}; // R-type

    RST   = 1'b0;
    stall = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset state before any clock edge
    #2 RST = 1'b1;
    #2 chk("reset_state", O_IDLE);
    step();
    RST = 1'b0;

    // Table: one evaluation cycle, then drain the bubble window
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].f3, vecs[i].eq, vecs[i].lt, vecs[i].ltu);
      step();
      chk($sformatf("vec%0d_eval", i), vecs[i].taken ? o_redir(vecs[i].sel) : O_IDLE);
      ex_valid = 1'b0;
      repeat (3) step();
      chk($sformatf("vec%0d_drained", i), O_IDLE);
    end

    // A: JAL full timing, 1 redirect + 2 flush cycles
    drive(1'b1, JAL, 3'b000, 1'b0, 1'b0, 1'b0);
    step();  chk("jal_redirect", o_redir(3'd3));
    ex_valid = 1'b0;
    step();  chk("jal_flush1", O_FLUSH);
    step();  chk("jal_flush2", O_FLUSH);
    step();  chk("jal_idle", O_IDLE);

    // B: JALR held in REDIRECT by stall, then one stall cycle inside FLUSH
    drive(1'b1, JALR, 3'b000, 1'b0, 1'b0, 1'b0);
    step();  chk("jalr_redirect0", o_redir(3'd1));
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("jalr_redirect%0d", k), o_redir(3'd1));
    end
    stall = 1'b0;
    ex_valid = 1'b0;
    step();  chk("jalr_flush1", O_FLUSH);
    stall = 1'b1;
    step();  chk("jalr_flush_stalled", O_FLUSH);
    stall = 1'b0;
    step();  chk("jalr_flush2", O_FLUSH);
    step();  chk("jalr_idle", O_IDLE);

    // D: stall in IDLE blocks capture; accepted once stall drops
    drive(1'b1, JAL, 3'b000, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    step();  chk("idle_stall_nocapture", O_IDLE);
    stall = 1'b0;
    step();  chk("idle_stall_release", o_redir(3'd3));
    ex_valid = 1'b0;
    repeat (3) step();
    chk("idle_stall_drained", O_IDLE);

    // E: async reset in the middle of FLUSH
    drive(1'b1, JAL, 3'b000, 1'b0, 1'b0, 1'b0);
    step();  chk("rst_pre_redirect", o_redir(3'd3));
    ex_valid = 1'b0;
    step();  chk("rst_pre_flush", O_FLUSH);
    #2 RST = 1'b1;
    #1 chk("rst_async_immediate", O_IDLE);
    step();  chk("rst_held", O_IDLE);
    RST = 1'b0;
    step();  chk("rst_release1", O_IDLE);
    step();  chk("rst_release2", O_IDLE);

    // C: JAL held in EX through FLUSH is ignored; stall with counter at 1; re-accept on first IDLE cycle
    drive(1'b1, JAL, 3'b000, 1'b0, 1'b0, 1'b0);
    step();  chk("b2b_redirect1", o_redir(3'd3));
    step();  chk("b2b_flush_cnt2", O_FLUSH);
    step();  chk("b2b_flush_cnt1", O_FLUSH);
    stall = 1'b1;
    step();  chk("b2b_flush_cnt1_stalled", O_FLUSH);
    stall = 1'b0;
    step();  chk("b2b_first_idle", O_IDLE);
    step();  chk("b2b_redirect2", o_redir(3'd3));
    ex_valid = 1'b0;
    repeat (3) step();
    chk("b2b_drained", O_IDLE);
`ifdef BRANCH_REDIRECT_STATS_EN
    checks++;
    if (redirect_count !== 16'd2) begin
      errors++;
      $display("FAIL redirect_count: got %0d expected 2", redirect_count);
    end
    checks++;
    if (taken_branch_count !== 16'd0) begin
      errors++;
      $display("FAIL taken_branch_count: got %0d expected 0", taken_branch_count);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Execute-stage control-flow resolver for the pipelined OTTER core.
- Decodes the instruction in EX, evaluates branch conditions and selects the redirect PC source for JAL/JALR/taken branches.
- Raises the squash signal consumed by the PC-source fixer and generates the flush enables for the IF/ID and ID/EX pipeline registers for a fixed bubble window.
- It is the producer end of the squash / PC-source interface: the fixer consumes it, this block drives it.

Parameters:
- FLUSH_CYCLES, 2, number of bubble cycles after a redirect; legal range 1..3.

Ports:
- CLK  in  1  core clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
- ex_opcode  in  7  opcode of the EX instruction.
- ex_func3  in  3  func3 of the EX instruction.
- br_eq  in  1  rs1 == rs2.
- br_lt  in  1  rs1 < rs2, signed.
- br_ltu  in  1  rs1 < rs2, unsigned.
- stall  in  1  pipeline stall from the hazard unit; EX contents are frozen.
- squash  out  1  redirect in progress; one accepted cycle per redirect.
- pc_source  out  3  PC mux select: 0 = PC+4, 1 = JALR, 2 = branch, 3 = JAL.
- flush_ifid  out  1  load a bubble into IF/ID.
- flush_idex  out  1  load a bubble into ID/EX.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: asynchronous. FSM goes to IDLE and the counter clears. squash, flush_ifid, flush_idex and busy are 0; pc_source is 0. Reset asserted mid-redirect or mid-flush aborts immediately; no residual pulse after release.
- Decode (combinational):
  - JAL 1101111 -> sel 3.
  - JALR 1100111 -> sel 1.
  - BRANCH 1100011 -> taken by func3: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 ltu; 111 !ltu. func3 010/011 is never taken.
  - Taken branch -> sel 2.
  - All other opcodes -> no redirect.
- All outputs are registered; latency is 1 cycle from EX-stage evaluation to squash/pc_source.
- FSM states:
  - IDLE: all outputs 0. On a rising edge with ex_valid=1, stall=0 and redirect=1: latch sel, go to REDIRECT. If stall=1, do not capture; the frozen EX instruction is re-evaluated next cycle.
  - REDIRECT: squash=1, pc_source=latched sel, flush_ifid=1, flush_idex=1, busy=1.
    - stall=1: hold the state and all outputs unchanged.
    - stall=0: load counter=FLUSH_CYCLES, go to FLUSH.
  - FLUSH: squash=0, pc_source=0, flush_ifid=1, flush_idex=1, busy=1.
    - Counter decrements only when stall=0.
    - On the edge where the counter goes 1 -> 0, go to IDLE.
    - ex_valid/redirect inputs are ignored in this state: the instructions are wrong-path bubbles.
- Back-to-back: the first cycle in IDLE after FLUSH may accept a new redirect. Minimum redirect spacing is 2 + FLUSH_CYCLES cycles.
- Counter: 2 bits, no wrap; it never decrements below 0.
- Simultaneous stall and a FLUSH counter at 1: stall wins, and the state stays in FLUSH with counter=1.
- ex_valid=0 in IDLE: no capture regardless of opcode.

Optional Feature:
- Macro: BRANCH_REDIRECT_STATS_EN.
- Defined:
  - Adds output redirect_count[15:0]. It increments by 1 on each IDLE -> REDIRECT transition and wraps 0xFFFF -> 0x0000.
  - Adds output taken_branch_count[15:0]. It counts only sel=2 captures, with the same wrap rule.
  - Both are cleared by RST.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset mid-flush: assert RST asynchronously during FLUSH -> all outputs 0 immediately; busy=0 after release; no squash pulse.
- JAL, ex_valid=1, stall=0, FLUSH_CYCLES=2 -> next cycle squash=1 and pc_source=3. Following 2 cycles: pc_source=0 with flush_ifid=1 and flush_idex=1. Then busy=0. Total flush assertion = 3 cycles.
- BNE (func3=001) with br_eq=1 -> no redirect and all outputs stay 0. With br_eq=0 -> squash=1 and pc_source=2 for 1 cycle.
- BGEU (func3=111) with br_ltu=0 -> pc_source=2. func3=010 with any flags -> no redirect.
- JALR captured, stall held high 3 cycles in REDIRECT -> squash=1 and pc_source=1 for 4 cycles. stall=1 for 1 cycle in FLUSH -> flush window extends by 1 cycle.
- Second JAL presented in EX during FLUSH -> ignored. JAL presented on the first IDLE cycle -> accepted. With BRANCH_REDIRECT_STATS_EN defined -> redirect_count=2 and taken_branch_count=0.
